// File: rtl/duty_softstart.sv
// Soft-start duty slew for the half-bridge PWM: steps duty toward a clamped target once per
// update tick derived from clk_int. Optional ramp-down on enable loss via DUTY_RAMP_DOWN_EN.
module duty_softstart #(
    parameter int unsigned D_MAX    = 1000,
    parameter int unsigned STEP     = 4,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       clk_int,
    input  logic       enable,
    input  logic       fault,
    input  logic [9:0] d_target,
    output logic [9:0] d_halfbridge,
    output logic       at_target,
    output logic       fault_latched
);

`ifdef DUTY_RAMP_DOWN_EN
    typedef enum logic [2:0] {StIdle, StRamp, StRun, StRampDn, StFault} state_e;
`else
    typedef enum logic [2:0] {StIdle, StRamp, StRun, StFault} state_e;
`endif

    localparam logic [10:0] DMax    = 11'(D_MAX);
    localparam logic [10:0] StepW   = 11'(STEP);
    localparam logic [3:0]  DivLast = 4'(TICK_DIV - 1);

    state_e      state_q, state_d;
    logic [2:0]  sync_q;
    logic [3:0]  div_q, div_d;
    logic [9:0]  duty_q, duty_d;
    logic [9:0]  tgt_q, tgt_d;
    logic        tick_raw;
    logic        upd;
    logic [10:0] tgt_in;
    logic [10:0] stepped;

    // Move cur toward tgt by at most StepW; the final step snaps exactly onto tgt.
    function automatic logic [10:0] step_toward(input logic [10:0] cur, input logic [10:0] tgt);
        logic [10:0] res;
        if (tgt >= cur) begin
            res = ((tgt - cur) <= StepW) ? tgt : cur + StepW;
        end else begin
            res = ((cur - tgt) <= StepW) ? tgt : cur - StepW;
        end
        return res;
    endfunction

    // sync_q[1] is the synchronised level, sync_q[2] its previous value for edge detect.
    assign tick_raw = sync_q[1] & ~sync_q[2] & ce;
    assign upd      = tick_raw && (div_q == DivLast);

    always_comb begin
        div_d = div_q;
        if (tick_raw) begin
            div_d = upd ? 4'd0 : 4'(div_q + 4'd1);
        end
    end

    assign tgt_in  = ({1'b0, d_target} > DMax) ? DMax : {1'b0, d_target};
    assign stepped = step_toward({1'b0, duty_q}, tgt_in);

`ifdef DUTY_RAMP_DOWN_EN
    logic [9:0] duty_dn;
    assign duty_dn = ({1'b0, duty_q} <= StepW) ? 10'd0 : duty_q - StepW[9:0];
`endif

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        // Fault wins over everything, including ce and a coincident update.
        if (fault) begin
            state_d = StFault;
            duty_d  = 10'd0;
        end else if (ce) begin
            unique case (state_q)
                StIdle: begin
                    duty_d = 10'd0;
                    if (upd && enable) begin
                        tgt_d   = tgt_in[9:0];
                        duty_d  = stepped[9:0];
                        state_d = (stepped == tgt_in) ? StRun : StRamp;
                    end
                end
                StRamp, StRun: begin
                    if (!enable) begin
`ifdef DUTY_RAMP_DOWN_EN
                        state_d = StRampDn;
                        if (upd) begin
                            duty_d = duty_dn;
                            if (duty_dn == 10'd0) state_d = StIdle;
                        end
`else
                        state_d = StIdle;
                        duty_d  = 10'd0;
`endif
                    end else if (upd) begin
                        tgt_d  = tgt_in[9:0];
                        duty_d = stepped[9:0];
                        if (state_q == StRamp && stepped == tgt_in) state_d = StRun;
                    end
                end
`ifdef DUTY_RAMP_DOWN_EN
                StRampDn: begin
                    if (enable) begin
                        // Resume ramping from the current duty, no jump.
                        state_d = StRamp;
                        if (upd) begin
                            tgt_d   = tgt_in[9:0];
                            duty_d  = stepped[9:0];
                            state_d = (stepped == tgt_in) ? StRun : StRamp;
                        end
                    end else if (duty_q == 10'd0) begin
                        state_d = StIdle;
                    end else if (upd) begin
                        duty_d = duty_dn;
                        if (duty_dn == 10'd0) state_d = StIdle;
                    end
                end
`endif
                StFault: begin
                    duty_d = 10'd0;
                    if (!enable) state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                    duty_d  = 10'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sync_q  <= 3'd0;
            div_q   <= 4'd0;
            duty_q  <= 10'd0;
            tgt_q   <= 10'd0;
        end else begin
            state_q <= state_d;
            // Synchroniser runs regardless of ce so an edge seen while ce=0 is lost.
            sync_q  <= {sync_q[1:0], clk_int};
            div_q   <= div_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
        end
    end

    assign d_halfbridge  = duty_q;
    assign at_target     = (state_q == StRun) && (duty_q == tgt_q);
    assign fault_latched = (state_q == StFault);

endmodule

// File: tb/tb_duty_softstart.sv
// Directed bench for duty_softstart: vector table plus hand sequences for latency, clamp,
// fault priority, slew, enable loss, async reset and the tick divider.
module tb_duty_softstart;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b1;
    logic       ce3 = 1'b1;
    logic       clk_int = 1'b0;
    logic       enable = 1'b0;
    logic       en3 = 1'b0;
    logic       fault = 1'b0;
    logic [9:0] d_target = 10'd0;
    logic [9:0] d_halfbridge, duty3;
    logic       at_target, fault_latched, at3, fl3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    duty_softstart #(.D_MAX(1000), .STEP(4), .TICK_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .clk_int(clk_int), .enable(enable), .fault(fault),
        .d_target(d_target), .d_halfbridge(d_halfbridge), .at_target(at_target),
        .fault_latched(fault_latched)
    );

    duty_softstart #(.D_MAX(1000), .STEP(4), .TICK_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ce(ce3), .clk_int(clk_int), .enable(en3), .fault(fault),
        .d_target(d_target), .d_halfbridge(duty3), .at_target(at3), .fault_latched(fl3)
    );

    typedef struct {
        logic       en;
        logic       flt;
        logic [9:0] tgt;
        logic       pulse;
        logic [9:0] duty;
        logic       at;
        logic       fl;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // clk_int pulse; duty must hold for 2 clk edges and change on the 3rd.
    task automatic tick(input int pre, input int post, input string nm);
        clk_int = 1'b1;
        step(2);
        chk({nm, " pre"}, {1'b0, d_halfbridge}, 11'(pre));
        step(1);
        chk(nm, {1'b0, d_halfbridge}, 11'(post));
        step(1);
        clk_int = 1'b0;
        step(4);
    endtask

    task automatic pulse_only();
        clk_int = 1'b1;
        step(4);
        clk_int = 1'b0;
        step(4);
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    initial begin
        int prev;
        //          en   flt  tgt     pulse duty    at    fl
        vecs[0]  = '{1'b1, 1'b0, 10'd20, 1'b1, 10'd4,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 10'd20, 1'b1, 10'd8,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 10'd20, 1'b1, 10'd12, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 10'd20, 1'b1, 10'd16, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 10'd20, 1'b1, 10'd20, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 10'd22, 1'b1, 10'd22, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 10'd14, 1'b1, 10'd18, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 10'd14, 1'b1, 10'd14, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 10'd14, 1'b0, 10'd14, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 10'd14, 1'b0, 10'd0,  1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 10'd14, 1'b0, 10'd0,  1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 10'd14, 1'b1, 10'd0,  1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 10'd14, 1'b0, 10'd0,  1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 10'd14, 1'b1, 10'd0,  1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 10'd0,  1'b1, 10'd0,  1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 10'd6,  1'b1, 10'd4,  1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 10'd6,  1'b1, 10'd6,  1'b1, 1'b0};

        #2;
        chk("reset duty", {1'b0, d_halfbridge}, 11'd0);
        chk("reset at_target", {10'd0, at_target}, 11'd0);
        chk("reset fault_latched", {10'd0, fault_latched}, 11'd0);
        step(2);
        rst_n = 1'b1;
        step(2);

        prev = 0;
        for (int i = 0; i < NV; i++) begin
            enable   = vecs[i].en;
            fault    = vecs[i].flt;
            d_target = vecs[i].tgt;
            if (vecs[i].pulse) tick(prev, int'(vecs[i].duty), $sformatf("row%0d duty", i));
            else step(1);
            chk($sformatf("row%0d duty", i), {1'b0, d_halfbridge}, {1'b0, vecs[i].duty});
            chk($sformatf("row%0d at_target", i), {10'd0, at_target}, {10'd0, vecs[i].at});
            chk($sformatf("row%0d fault_latched", i), {10'd0, fault_latched},
                {10'd0, vecs[i].fl});
            prev = int'(vecs[i].duty);
        end

        // Fault asserted in the very cycle the update lands.
        d_target = 10'd20;
        clk_int  = 1'b1;
        step(2);
        chk("fault+upd pre", {1'b0, d_halfbridge}, 11'd6);
        fault = 1'b1;
        step(1);
        chk("fault+upd duty", {1'b0, d_halfbridge}, 11'd0);
        chk("fault+upd latched", {10'd0, fault_latched}, 11'd1);
        step(1);
        clk_int = 1'b0;
        step(4);
        fault = 1'b0;
        step(2);
        chk("fault hold en=1", {10'd0, fault_latched}, 11'd1);
        enable = 1'b0;
        step(1);
        chk("fault exit", {10'd0, fault_latched}, 11'd0);

        // Ramp to 100, then fault between ticks.
        enable   = 1'b1;
        d_target = 10'd100;
        for (int k = 1; k <= 25; k++) tick(4 * (k - 1), 4 * k, $sformatf("ramp100 #%0d", k));
        chk("run100 at_target", {10'd0, at_target}, 11'd1);
        step(3);
        fault = 1'b1;
        step(1);
        chk("fault100 duty", {1'b0, d_halfbridge}, 11'd0);
        chk("fault100 latched", {10'd0, fault_latched}, 11'd1);
        fault = 1'b0;
        step(2);
        chk("fault100 hold", {10'd0, fault_latched}, 11'd1);
        enable = 1'b0;
        step(1);
        chk("fault100 exit", {10'd0, fault_latched}, 11'd0);

        // Target above D_MAX saturates at 1000.
        enable   = 1'b1;
        d_target = 10'd1023;
        for (int k = 1; k <= 252; k++)
            tick(min_i(4 * (k - 1), 1000), min_i(4 * k, 1000), $sformatf("sat #%0d", k));
        chk("sat at_target", {10'd0, at_target}, 11'd1);
        fault = 1'b1;
        step(1);
        fault  = 1'b0;
        enable = 1'b0;
        step(1);
        chk("sat exit", {10'd0, fault_latched}, 11'd0);

        // Slew down by less than two steps: 50 -> 46 -> 45.
        enable   = 1'b1;
        d_target = 10'd50;
        for (int k = 1; k <= 12; k++) tick(4 * (k - 1), 4 * k, $sformatf("ramp50 #%0d", k));
        tick(48, 50, "ramp50 snap");
        chk("run50 at_target", {10'd0, at_target}, 11'd1);
        d_target = 10'd45;
        tick(50, 46, "slew 46");
        chk("slew at_target low", {10'd0, at_target}, 11'd0);
        tick(46, 45, "slew 45");
        chk("slew at_target high", {10'd0, at_target}, 11'd1);

        // Enable loss from RUN at 12.
        fault = 1'b1;
        step(1);
        fault  = 1'b0;
        enable = 1'b0;
        step(1);
        enable   = 1'b1;
        d_target = 10'd12;
        tick(0, 4, "ramp12 4");
        tick(4, 8, "ramp12 8");
        tick(8, 12, "ramp12 12");
        chk("run12 at_target", {10'd0, at_target}, 11'd1);
        enable = 1'b0;
`ifdef DUTY_RAMP_DOWN_EN
        step(1);
        chk("rampdn hold", {1'b0, d_halfbridge}, 11'd12);
        chk("rampdn at_target", {10'd0, at_target}, 11'd0);
        tick(12, 8, "rampdn 8");
        enable = 1'b1;
        tick(8, 12, "rampdn resume");
        chk("resume at_target", {10'd0, at_target}, 11'd1);
        enable = 1'b0;
        step(1);
        tick(12, 8, "rampdn2 8");
        tick(8, 4, "rampdn2 4");
        tick(4, 0, "rampdn2 0");
        chk("rampdn end at_target", {10'd0, at_target}, 11'd0);
        tick(0, 0, "idle hold");
`else
        step(1);
        chk("drop duty", {1'b0, d_halfbridge}, 11'd0);
        chk("drop at_target", {10'd0, at_target}, 11'd0);
        tick(0, 0, "idle hold");
`endif
        enable = 1'b1;
        tick(0, 4, "restart");

        // Asynchronous reset mid-cycle.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset duty", {1'b0, d_halfbridge}, 11'd0);
        step(1);
        rst_n  = 1'b1;
        enable = 1'b0;
        step(2);

        // TICK_DIV=3 with one clk_int edge dropped by ce=0.
        en3      = 1'b1;
        d_target = 10'd20;
        pulse_only();
        chk("div3 A", {1'b0, duty3}, 11'd0);
        ce3 = 1'b0;
        pulse_only();
        ce3 = 1'b1;
        chk("div3 B dropped", {1'b0, duty3}, 11'd0);
        pulse_only();
        chk("div3 C", {1'b0, duty3}, 11'd0);
        clk_int = 1'b1;
        step(2);
        chk("div3 D pre", {1'b0, duty3}, 11'd0);
        step(1);
        chk("div3 D", {1'b0, duty3}, 11'd4);
        step(1);
        clk_int = 1'b0;
        step(4);
        pulse_only();
        pulse_only();
        chk("div3 F", {1'b0, duty3}, 11'd4);
        pulse_only();
        chk("div3 G", {1'b0, duty3}, 11'd8);
        chk("div3 at_target", {10'd0, at3}, 11'd0);
        chk("div3 fault_latched", {10'd0, fl3}, 11'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
